// File: rtl/bip_tx_pkg.sv
// Shared types and constants for the BIP result UART transmitter.
// Optional even parity is selected with the BIP_TX_PARITY_EN macro.
package bip_tx_pkg;

    localparam int DEF_CLK_FREQ   = 10_000_000;
    localparam int DEF_BAUD_RATE  = 9600;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DIV            = DEF_CLK_FREQ / DEF_BAUD_RATE;
    localparam int BAUD_W         = $clog2(DIV);
    localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

`ifdef BIP_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef BIP_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bip_tx_fifo.sv
// First-word fall-through result FIFO; pointers carry an extra wrap bit
// so full and empty are told apart without a separate counter.
module bip_tx_fifo
    import bip_tx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = calc_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;

    // Pointer registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
        end else begin
            if (i_wr_en) begin
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            end
            if (i_rd_en) begin
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[wr_ptr_q[PW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q[PW-1:0]];
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/bip_result_uart_tx.sv
// Buffers 16-bit BIP results and sends each as two UART frames, high byte first.
// Define BIP_TX_PARITY_EN for 8E1 frames; default is 8N1.
module bip_result_uart_tx
    import bip_tx_pkg::*;
#(
    parameter int NB_DATA    = 16,
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_locked,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_full,
    output logic               o_overflow
);

    localparam int DIV_C    = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int BAUD_W_C = calc_w(DIV_C);
    localparam logic [BAUD_W_C-1:0] BAUD_LAST = BAUD_W_C'(DIV_C - 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W_C-1:0]  baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic                 byte_idx_q, byte_idx_d;
    logic [NB_DATA-1:0]   hold_q, hold_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           byte_sel_s;
    logic                 baud_last_s;
    logic                 wr_en_s, rd_en_s;
    logic [NB_DATA-1:0]   fifo_rdata_s;
    logic                 fifo_full_s, fifo_empty_s;

    // A push while full is dropped even if a pop frees a slot this cycle
    assign wr_en_s = i_valid & i_locked & ~fifo_full_s;

    bip_tx_fifo #(
        .WIDTH (NB_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (wr_en_s),
        .i_wr_data (i_data),
        .i_rd_en   (rd_en_s),
        .o_rd_data (fifo_rdata_s),
        .o_full    (fifo_full_s),
        .o_empty   (fifo_empty_s)
    );

    assign baud_last_s = (baud_q == BAUD_LAST);

    // Next-state, counters, holding register and registered line value
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        hold_d     = hold_q;
        rd_en_s    = 1'b0;
        ovf_d      = ovf_q | (i_valid & i_locked & fifo_full_s);
        case (state_q)
            ST_IDLE: begin
                baud_d = {BAUD_W_C{1'b0}};
                bit_d  = 3'd0;
                if (i_locked && !fifo_empty_s) begin
                    rd_en_s    = 1'b1;
                    hold_d     = fifo_rdata_s;
                    byte_idx_d = 1'b0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W_C{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W_C'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = {BAUD_W_C{1'b0}};
                    if (bit_q == 3'd7) begin
`ifdef BIP_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W_C'(1);
                end
            end
`ifdef BIP_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W_C{1'b0}};
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W_C'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = {BAUD_W_C{1'b0}};
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W_C'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line value follows the state being entered, so o_tx is a flop
        byte_sel_s = byte_idx_d ? hold_d[7:0] : hold_d[15:8];
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = byte_sel_s[bit_d];
`ifdef BIP_TX_PARITY_EN
            ST_PARITY: tx_d = ^byte_sel_s;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= {BAUD_W_C{1'b0}};
            bit_q      <= 3'd0;
            byte_idx_q <= 1'b0;
            hold_q     <= {NB_DATA{1'b0}};
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_tx       = tx_q;
    assign o_overflow = ovf_q;
    assign o_full     = fifo_full_s;
    assign o_busy     = ~fifo_empty_s | (state_q != ST_IDLE);

endmodule

// File: tb/tb_bip_result_uart_tx.sv
// Scoreboard bench for bip_result_uart_tx at DIV=10: a UART monitor decodes
// o_tx and checks each byte, start/stop bits, timing and inter-frame gaps.
module tb_bip_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        locked;
    logic        valid;
    logic [15:0] data;
    logic        tx, busy, full, ovf;

    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    typedef struct {
        logic [7:0] b;
        int         gap;
        longint     start;
    } exp_t;
    exp_t exp_q[$];

    bip_result_uart_tx #(
        .NB_DATA    (16),
        .CLK_FREQ   (10_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_locked   (locked),
        .i_data     (data),
        .i_valid    (valid),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_full     (full),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] b, input int gap, input longint start);
        exp_t e;
        e.b = b;
        e.gap = gap;
        e.start = start;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [15:0] w, input int gap_hi, input longint start);
        push_exp(w[15:8], gap_hi, start);
        push_exp(w[7:0], 0, -1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w);
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_busy", busy, 0);
        tick(3);
    endtask

    // UART monitor: decodes frames sampled mid-bit and compares with the scoreboard
    initial begin
        int         idle_cnt = 0;
        longint     start_c;
        int         gap;
        logic       aborted, sb, pb;
        logic [7:0] rx;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle_cnt = 0;
                continue;
            end
            if (tx) begin
                idle_cnt++;
            end else begin
                start_c  = cyc;
                gap      = idle_cnt;
                idle_cnt = 0;
                aborted  = 1'b0;
                sb = 1'b1;
                pb = 1'b0;
                rx = 8'h00;
                for (int t = 1; t < 100; t++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (t == 5) sb = tx;
                    if (t >= 15 && t <= 85 && (t % 10) == 5) rx[(t - 15) / 10] = tx;
                    if (t == 95) pb = tx;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", rx, e.b);
                        check("start_bit", sb, 0);
                        check("stop_bit", pb, 1);
                        if (e.gap >= 0) check("frame_gap", gap, e.gap);
                        if (e.start >= 0) check("start_cycle", start_c, e.start);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint     c;
        int         lows;
        logic [15:0] w;
        rst    = 1'b1;
        locked = 1'b1;
        valid  = 1'b0;
        data   = 16'h0000;

        // Reset and idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_ovf", ovf, 0);
        end
        check("rst_full", full, 0);
        rst = 1'b0;
        tick(5);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);

        // Single word: 200 line cycles, then not busy
        c = cyc;
        push_word(16'hA55A, -1, c + 2);
        send(16'hA55A);
        tick(200);
        check("single_busy_last", busy, 1);
        tick(1);
        check("single_busy_done", busy, 0);
        check("single_queue", exp_q.size(), 0);

        // Back-to-back words: one idle cycle between words
        tick(3);
        c = cyc;
        push_word(16'h0001, -1, c + 2);
        push_word(16'hFFFF, 1, c + 203);
        send(16'h0001);
        send(16'hFFFF);
        wait_idle(600);

        // Overflow: 10 consecutive pushes, 9 accepted
        c = cyc;
        for (int i = 0; i < 10; i++) begin
            w = {8'(8'h10 + i), 8'(8'hE0 + i)};
            if (i < 9) push_word(w, (i == 0) ? -1 : 1, (i == 0) ? c + 2 : -1);
            data  = w;
            valid = 1'b1;
            @(negedge clk);
            if (i == 8) begin
                check("ovf_full_at_8", full, 1);
                check("ovf_clear_at_8", ovf, 0);
            end
            if (i == 9) begin
                check("ovf_full_at_9", full, 1);
                check("ovf_set_at_9", ovf, 1);
            end
        end
        valid = 1'b0;
        tick(1);
        check("ovf_sticky_early", ovf, 1);
        wait_idle(3000);
        check("ovf_sticky_late", ovf, 1);
        check("ovf_full_drained", full, 0);

        // Lock gating
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("lock_ovf_after_rst", ovf, 0);
        locked = 1'b0;
        send(16'h1234);
        tick(30);
        check("lock_busy", busy, 0);
        check("lock_ovf", ovf, 0);
        check("lock_full", full, 0);
        locked = 1'b1;
        tick(2);
        c = cyc;
        push_word(16'h1234, -1, c + 2);
        send(16'h1234);
        wait_idle(400);

        // Reset mid-frame: word 0xA5C3 with 0x0F0F queued behind it
        c = cyc;
        send(16'hA5C3);
        send(16'h0F0F);
        tick(50);
        check("midrst_pre_tx", tx, 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_full", full, 0);
        tick(2);
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("midrst_no_frames", lows, 0);
        check("midrst_busy_after", busy, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
